tnn_popcount_accum: RTL and testbench
=====================================

Name: tnn_popcount_accum

Overview:
Streaming, parametrised ternary-neuron popcount engine for the TNN datapath. It generalises the fixed 14-input combinational popcount to an arbitrary input width per beat and multi-beat frames, for neurons with more inputs than one word carries. Each beat carries a positive-match vector and a negative-match vector. The block accumulates the signed difference of their popcounts over a frame and emits the neuron's pre-activation sum plus a ternary activation from two thresholds. It sits between the weight/activation XNOR stage and the layer output buffer, with valid/ready on both sides.

Parameters:
IN_W, 14, bits per beat in each of pos_bits/neg_bits (>=1)
MAX_BEATS, 8, maximum beats per frame before overflow is flagged (>=1)
CNT_W, $clog2(IN_W+1), per-beat popcount width (derived, not overridden)
ACC_W, $clog2(IN_W*MAX_BEATS+1)+1, signed accumulator width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_last  in  1  final beat of frame
pos_bits  in  IN_W  inputs contributing +1 each
neg_bits  in  IN_W  inputs contributing -1 each
thr_lo  in  ACC_W  signed lower threshold, sampled on first beat of frame
thr_hi  in  ACC_W  signed upper threshold, sampled on first beat of frame
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_sum  out  ACC_W  signed frame sum, two's complement
out_trit  out  2  activation: 2'b01=+1, 2'b00=0, 2'b11=-1
out_ovf  out  1  frame exceeded MAX_BEATS; out_sum saturated

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_trit=2'b00, out_ovf=0. The accumulator, beat counter and S1 are cleared and the FSM enters ACCUM.
- Reset mid-frame discards the partial frame. No result is emitted for it.
- Pipeline stage S1 registers popcount(pos_bits), popcount(neg_bits), last and a valid bit for each accepted beat. Counts are exact and CNT_W unsigned.
- Stage S2 adds (pcnt_pos - pcnt_neg), sign-extended to ACC_W, into the accumulator.
- FSM states:
  - ACCUM: in_ready=1. An accepted beat enters S1. An accepted beat with in_last=1 moves the FSM to DRAIN.
  - DRAIN: in_ready=0. S1 (the last beat) folds into the accumulator. The output registers load the final sum, trit and ovf. Then go to HOLD.
  - HOLD: out_valid=1 and in_ready=0. Outputs are stable until out_ready. On a handshake: clear the accumulator, beat counter and ovf, return to ACCUM, and drop out_valid the next cycle.
- Latency: last beat accepted at cycle t gives out_valid at t+2. Within a frame, throughput is 1 beat/clk. The minimum gap between frames is 3 cycles (DRAIN + HOLD + handshake).
- Beat counter counts accepted beats per frame. Threshold sampling happens when the counter is 0.
- If an accepted beat would make the count exceed MAX_BEATS: set ovf sticky, still accept the beat, and clamp the accumulator to its signed min/max instead of wrapping.
- A single-beat frame (in_last on the first beat) is legal.
- A beat with in_valid=0 leaves all state unchanged. in_last is ignored unless the beat is accepted.
- Trit rule: sum > thr_hi gives +1; else sum < thr_lo gives -1; else 0. If thr_lo > thr_hi, +1 takes priority.
- A bit set in both pos_bits and neg_bits contributes 0 net. This is legal, not an error.
- out_valid never drops without a handshake. in_ready does not depend combinationally on in_valid.

Decomposition:
- Shared package tnn_pkg:
  - trit encoding constants TRIT_POS/TRIT_ZERO/TRIT_NEG.
  - clog2-based width helper functions.
  - FSM state typedef (ACCUM, DRAIN, HOLD).
- Sub-module tnn_popcount_tree: parametrised IN_W-input exact combinational popcount adder tree, CNT_W output. It is instantiated twice, for pos and neg. The same sub-module is the drop-in point for approximate variants later.

Test Plan:
1. Reset release, IN_W=14: one beat pos=14'h3FFF, neg=0, last=1, thr_lo=-3, thr_hi=3 -> out_valid 2 cycles later, out_sum=14, trit=2'b01, ovf=0.
2. Three-beat frame with pos=14'h00FF/neg=14'h0F00 per beat, thr_lo=-2, thr_hi=2 -> sum=3*(8-4)=12, trit=+1. in_ready low in DRAIN/HOLD.
3. Balanced frame: pos=14'h0003, neg=14'h000C, single beat, thr_lo=0, thr_hi=0 -> sum=0, trit=2'b00. Also pos=neg=14'h3FFF -> sum=0.
4. Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_valid beats not accepted. Release -> handshake, next frame accepted in ACCUM the following cycle.
5. Overflow: 10 beats of neg=14'h3FFF, MAX_BEATS=8 -> ovf=1, out_sum clamped to signed min (-(2^(ACC_W-1))), trit=-1.
6. Assert rst_n low mid-frame after 2 beats, then run a 1-beat frame pos=14'h0001 -> out_sum=1, with no stale contribution.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary-neuron popcount datapath: trit encoding,
// frame FSM states and width helpers.
package tnn_pkg;

    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int cnt_width(input int in_w);
        return $clog2(in_w + 1);
    endfunction

    function automatic int acc_width(input int in_w, input int max_beats);
        return $clog2(in_w * max_beats + 1) + 1;
    endfunction

    // Beat counter must be able to hold MAX_BEATS+1 so overflow stays visible.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 2);
    endfunction

endpackage

// File: rtl/tnn_popcount_tree.sv
// Exact combinational popcount of an IN_W-bit vector; the swap-in point for
// approximate counters later.
module tnn_popcount_tree
    import tnn_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int CNT_W = cnt_width(IN_W)
) (
    input  logic [IN_W-1:0]  bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < IN_W; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/tnn_popcount_accum.sv
// Streaming ternary-neuron popcount engine: accumulates popcount(pos)-popcount(neg)
// over multi-beat frames and emits the signed sum plus a thresholded trit.
module tnn_popcount_accum
    import tnn_pkg::*;
#(
    parameter int IN_W      = 14,
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = cnt_width(IN_W),
    parameter int ACC_W     = acc_width(IN_W, MAX_BEATS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [IN_W-1:0]         pos_bits,
    input  logic [IN_W-1:0]         neg_bits,
    input  logic signed [ACC_W-1:0] thr_lo,
    input  logic signed [ACC_W-1:0] thr_hi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic [1:0]              out_trit,
    output logic                    out_ovf
);

    // Valid/ready: a beat transfers on any edge where in_valid && in_ready, a result
    // on any edge where out_valid && out_ready; ready/valid are pure state decodes.

    localparam int BC_W  = beat_cnt_width(MAX_BEATS);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [BC_W-1:0] BC_LIMIT = BC_W'(MAX_BEATS);
    localparam logic [BC_W-1:0] BC_SAT   = BC_W'(MAX_BEATS + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_next;

    logic                    accept;
    logic                    handshake;
    logic [CNT_W-1:0]        pcnt_pos, pcnt_neg;
    logic [CNT_W-1:0]        s1_pos, s1_neg;
    logic                    s1_valid, s1_last;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic signed [ACC_W-1:0] thr_lo_q, thr_hi_q;
    logic [BC_W-1:0]         beat_cnt;
    logic                    ovf;
    logic [SUM_W-1:0]        sum_ext;
    logic [1:0]              trit_next;

    tnn_popcount_tree #(.IN_W(IN_W), .CNT_W(CNT_W)) u_pop_pos (
        .bits  (pos_bits),
        .count (pcnt_pos)
    );

    tnn_popcount_tree #(.IN_W(IN_W), .CNT_W(CNT_W)) u_pop_neg (
        .bits  (neg_bits),
        .count (pcnt_neg)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign handshake = (state == HOLD) && out_ready;

    // One extra bit of headroom lets a single beat's delta be detected as overflow.
    assign sum_ext = {acc[ACC_W-1], acc} + SUM_W'(s1_pos) - SUM_W'(s1_neg);

    always_comb begin
        acc_next = acc;
        if (s1_valid) begin
            if (sum_ext[SUM_W-1] != sum_ext[SUM_W-2]) begin
                acc_next = sum_ext[SUM_W-1] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_next = sum_ext[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        trit_next = TRIT_ZERO;
        if (acc_next > thr_hi_q) begin
            trit_next = TRIT_POS;
        end else if (acc_next < thr_lo_q) begin
            trit_next = TRIT_NEG;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && in_last) state_next = DRAIN;
            DRAIN:   state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pos   <= '0;
            s1_neg   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
                s1_pos  <= pcnt_pos;
                s1_neg  <= pcnt_neg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
            thr_lo_q <= '0;
            thr_hi_q <= '0;
        end else if (handshake) begin
            acc      <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            acc <= acc_next;
            if (accept) begin
                if (beat_cnt != BC_SAT) beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt >= BC_LIMIT) ovf <= 1'b1;
                if (beat_cnt == '0) begin
                    thr_lo_q <= thr_lo;
                    thr_hi_q <= thr_hi;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_trit <= TRIT_ZERO;
            out_ovf  <= 1'b0;
        end else if (state == DRAIN && s1_valid && s1_last) begin
            out_sum  <= acc_next;
            out_trit <= trit_next;
            out_ovf  <= ovf;
        end
    end

endmodule

// File: tb/tb_tnn_popcount_accum.sv
// Randomised and directed checks of tnn_popcount_accum against a frame-level
// arithmetic model (saturating signed sum, beat count, threshold rule).
module tb_tnn_popcount_accum;

    localparam int IN_W      = 14;
    localparam int MAX_BEATS = 8;
    localparam int ACC_W     = $clog2(IN_W * MAX_BEATS + 1) + 1;
    localparam int ACC_MAXV  = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MINV  = -(1 << (ACC_W - 1));

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [IN_W-1:0]         pos_bits;
    logic [IN_W-1:0]         neg_bits;
    logic signed [ACC_W-1:0] thr_lo;
    logic signed [ACC_W-1:0] thr_hi;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_sum;
    logic [1:0]              out_trit;
    logic                    out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IN_W-1:0] beat_pos [64];
    logic [IN_W-1:0] beat_neg [64];

    tnn_popcount_accum #(.IN_W(IN_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .pos_bits  (pos_bits),
        .neg_bits  (neg_bits),
        .thr_lo    (thr_lo),
        .thr_hi    (thr_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_trit  (out_trit),
        .out_ovf   (out_ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_frame(input int n, input int lo, input int hi,
                                        output int s, output logic [1:0] t, output logic o);
        s = 0;
        for (int i = 0; i < n; i++) begin
            s = s + $countones(beat_pos[i]) - $countones(beat_neg[i]);
            if (s > ACC_MAXV) s = ACC_MAXV;
            if (s < ACC_MINV) s = ACC_MINV;
        end
        o = (n > MAX_BEATS);
        if (s > hi)      t = 2'b01;
        else if (s < lo) t = 2'b11;
        else             t = 2'b00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_frame(input int n, input int lo, input int hi, input bit gaps,
                               output int lat, output logic drain_ready);
        int waitc;
        int junk;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                pos_bits = IN_W'($urandom);
                neg_bits = IN_W'($urandom);
                @(posedge clk); #1;
            end
            waitc = 0;
            while (!in_ready && waitc < 50) begin
                @(posedge clk); #1;
                waitc++;
            end
            in_valid = 1'b1;
            pos_bits = beat_pos[i];
            neg_bits = beat_neg[i];
            in_last  = (i == n - 1);
            if (i == 0) begin
                thr_lo = lo[ACC_W-1:0];
                thr_hi = hi[ACC_W-1:0];
            end else begin
                junk   = int'($urandom);
                thr_lo = junk[ACC_W-1:0];
                thr_hi = junk[2*ACC_W-1:ACC_W];
            end
            @(posedge clk); #1;
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        drain_ready = in_ready;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
        n_checks++; if (out_trit !== 2'b00) begin n_fail++; $display("FAIL reset_out_trit: got %b want 00", out_trit); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    endtask

    task automatic test_single_full();
        int lat; logic dr;
        beat_pos[0] = 14'h3FFF; beat_neg[0] = 14'h0000;
        drive_frame(1, -3, 3, 1'b0, lat, dr);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL single_drain_ready: got %b want 0", dr); end
        n_checks++; if (int'($signed(out_sum)) !== 14) begin n_fail++; $display("FAIL single_sum: got %0d want 14", $signed(out_sum)); end
        n_checks++; if (out_trit !== 2'b01) begin n_fail++; $display("FAIL single_trit: got %b want 01", out_trit); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b want 0", out_ovf); end
        consume();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_three_beat();
        int lat; logic dr;
        for (int i = 0; i < 3; i++) begin
            beat_pos[i] = 14'h00FF; beat_neg[i] = 14'h0F00;
        end
        drive_frame(3, -2, 2, 1'b0, lat, dr);
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL three_drain_ready: got %b want 0", dr); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL three_hold_ready: got %b want 0", in_ready); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL three_latency: got %0d want 2", lat); end
        n_checks++; if (int'($signed(out_sum)) !== 12) begin n_fail++; $display("FAIL three_sum: got %0d want 12", $signed(out_sum)); end
        n_checks++; if (out_trit !== 2'b01) begin n_fail++; $display("FAIL three_trit: got %b want 01", out_trit); end
        consume();
    endtask

    task automatic test_balanced();
        int lat; logic dr;
        logic [IN_W-1:0] pv [2];
        logic [IN_W-1:0] nv [2];
        pv[0] = 14'h0003; nv[0] = 14'h000C;
        pv[1] = 14'h3FFF; nv[1] = 14'h3FFF;
        for (int k = 0; k < 2; k++) begin
            beat_pos[0] = pv[k]; beat_neg[0] = nv[k];
            drive_frame(1, 0, 0, 1'b0, lat, dr);
            n_checks++; if (int'($signed(out_sum)) !== 0) begin n_fail++; $display("FAIL balanced_sum[%0d]: got %0d want 0", k, $signed(out_sum)); end
            n_checks++; if (out_trit !== 2'b00) begin n_fail++; $display("FAIL balanced_trit[%0d]: got %b want 00", k, out_trit); end
            n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL balanced_ovf[%0d]: got %b want 0", k, out_ovf); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic dr; int es; logic [1:0] et; logic eo;
        beat_pos[0] = 14'h0F0F; beat_neg[0] = 14'h0001;
        beat_pos[1] = 14'h0000; beat_neg[1] = 14'h00F0;
        model_frame(2, -1, 1, es, et, eo);
        drive_frame(2, -1, 1, 1'b0, lat, dr);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_last = 1'b1;
            pos_bits = IN_W'($urandom); neg_bits = IN_W'($urandom);
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b ready=%b want 1/0", c, out_valid, in_ready); end
            n_checks++; if (int'($signed(out_sum)) !== es || out_trit !== et) begin n_fail++; $display("FAIL bp_stable[%0d]: sum=%0d trit=%b want %0d/%b", c, $signed(out_sum), out_trit, es, et); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", in_ready, out_valid); end
        beat_pos[0] = 14'h0007; beat_neg[0] = 14'h0000;
        drive_frame(1, 5, 9, 1'b0, lat, dr);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
        n_checks++; if (int'($signed(out_sum)) !== 3) begin n_fail++; $display("FAIL bp_next_sum: got %0d want 3", $signed(out_sum)); end
        n_checks++; if (out_trit !== 2'b11) begin n_fail++; $display("FAIL bp_next_trit: got %b want 11", out_trit); end
        consume();
    endtask

    task automatic test_overflow();
        int lat; logic dr;
        for (int i = 0; i < 10; i++) begin
            beat_pos[i] = 14'h0000; beat_neg[i] = 14'h3FFF;
        end
        drive_frame(10, -3, 3, 1'b0, lat, dr);
        n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", out_ovf); end
        n_checks++; if (int'($signed(out_sum)) !== ACC_MINV) begin n_fail++; $display("FAIL ovf_sum: got %0d want %0d", $signed(out_sum), ACC_MINV); end
        n_checks++; if (out_trit !== 2'b11) begin n_fail++; $display("FAIL ovf_trit: got %b want 11", out_trit); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat; logic dr;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_last = 1'b0;
            pos_bits = 14'h3FFF; neg_bits = 14'h0000;
            thr_lo = '0; thr_hi = '0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0) begin n_fail++; $display("FAIL midreset_outputs: ready=%b valid=%b sum=%0d want 1/0/0", in_ready, out_valid, out_sum); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat_pos[0] = 14'h0001; beat_neg[0] = 14'h0000;
        drive_frame(1, 0, 0, 1'b0, lat, dr);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL midreset_latency: got %0d want 2", lat); end
        n_checks++; if (int'($signed(out_sum)) !== 1) begin n_fail++; $display("FAIL midreset_sum: got %0d want 1", $signed(out_sum)); end
        n_checks++; if (out_trit !== 2'b01 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL midreset_trit_ovf: trit=%b ovf=%b want 01/0", out_trit, out_ovf); end
        consume();
    endtask

    task automatic test_random();
        int lat; logic dr; int es; logic [1:0] et; logic eo;
        int n, lo, hi, mode, delay;
        for (int f = 0; f < 30; f++) begin
            n    = $urandom_range(1, 11);
            mode = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                beat_pos[i] = (mode == 1) ? 14'h3FFF : IN_W'($urandom);
                beat_neg[i] = (mode == 2) ? 14'h3FFF : IN_W'($urandom);
            end
            lo = int'($urandom_range(0, 40)) - 20;
            hi = int'($urandom_range(0, 40)) - 20;
            model_frame(n, lo, hi, es, et, eo);
            drive_frame(n, lo, hi, 1'b1, lat, dr);
            delay = $urandom_range(0, 3);
            repeat (delay) begin @(posedge clk); #1; end
            n_checks++; if (lat !== 2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_latency[%0d]: lat=%0d valid=%b want 2/1", f, lat, out_valid); end
            n_checks++; if (int'($signed(out_sum)) !== es) begin n_fail++; $display("FAIL rand_sum[%0d]: got %0d want %0d (n=%0d)", f, $signed(out_sum), es, n); end
            n_checks++; if (out_trit !== et) begin n_fail++; $display("FAIL rand_trit[%0d]: got %b want %b (lo=%0d hi=%0d)", f, out_trit, et, lo, hi); end
            n_checks++; if (out_ovf !== eo) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b (n=%0d)", f, out_ovf, eo, n); end
            consume();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        pos_bits = '0; neg_bits = '0; thr_lo = '0; thr_hi = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_single_full();
        test_three_beat();
        test_balanced();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
